// File: rtl/unsigned_div_pkg.sv
// -----------------------------------------------------------------------------
// unsigned_div_pkg
// Shared types and constants for the unsigned sequential restoring divider.
//   DIV_W      : default divisor/quotient/remainder width (dividend is 2*DIV_W)
//   ERR_CODE   : all-ones value returned as quotient and remainder on
//                divide-by-zero or quotient overflow (default width)
//   div_state_e: control FSM states
// -----------------------------------------------------------------------------
package unsigned_div_pkg;

  localparam int DIV_W = 8;

  localparam logic [DIV_W-1:0] ERR_CODE = {DIV_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage : unsigned_div_pkg

// File: rtl/unsigned_div_step.sv
// -----------------------------------------------------------------------------
// unsigned_div_step
// One combinational iteration of restoring division.
// Ports:
//   i_r        in  W    current partial remainder (always < i_divisor)
//   i_bit_in   in  1    next dividend bit, MSB first
//   i_divisor  in  W    divisor
//   o_r_next   out W    partial remainder after this iteration
//   o_q_bit    out 1    quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module unsigned_div_step
  import unsigned_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] i_r,
  input  logic         i_bit_in,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_r_next,
  output logic         o_q_bit
);

  logic [W:0] w_t;
  logic [W:0] w_diff;

  // T needs W+1 bits: R < divisor, so T < 2*divisor and the subtraction result
  // always fits back into W bits when it is taken.
  always_comb begin
    w_t    = {i_r, i_bit_in};
    w_diff = w_t - {1'b0, i_divisor};
    if (w_t >= {1'b0, i_divisor}) begin
      o_q_bit  = 1'b1;
      o_r_next = w_diff[W-1:0];
    end else begin
      o_q_bit  = 1'b0;
      o_r_next = w_t[W-1:0];
    end
  end

endmodule : unsigned_div_step

// File: rtl/unsigned_16by8_seq_div.sv
// -----------------------------------------------------------------------------
// unsigned_16by8_seq_div
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, one operation in flight, valid/ready on both sides.
// Ports:
//   clk        in  1    rising-edge clock
//   rst_n      in  1    asynchronous active-low reset
//   in_valid   in  1    operands valid
//   in_ready   out 1    block can accept operands (state is IDLE)
//   dividend   in  2W   unsigned dividend
//   divisor    in  W    unsigned divisor
//   out_valid  out 1    result valid (state is DONE)
//   out_ready  in  1    consumer accepts result
//   quotient   out W    unsigned quotient (all-ones on error)
//   remainder  out W    unsigned remainder (all-ones on error)
//   div_zero   out 1    divisor was zero
//   overflow   out 1    quotient would not fit in W bits
// -----------------------------------------------------------------------------
module unsigned_16by8_seq_div
  import unsigned_div_pkg::*;
#(
  parameter int W     = DIV_W,
  parameter int CNT_W = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam logic [W-1:0]     ERR_ONES = {W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  div_state_e       r_state;
  div_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_divisor;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_shift;
  logic [W-1:0]     r_quotient;
  logic [W-1:0]     r_remainder;
  logic             r_div_zero;
  logic             r_overflow;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_overflow;
  logic [W-1:0]     w_r_next;
  logic             w_q_bit;

  unsigned_div_step #(
    .W (W)
  ) u_step (
    .i_r       (r_rem),
    .i_bit_in  (r_shift[W-1]),
    .i_divisor (r_divisor),
    .o_r_next  (w_r_next),
    .o_q_bit   (w_q_bit)
  );

  // Operand classification at the accept edge.
  always_comb begin
    w_accept   = in_valid && (r_state == IDLE);
    w_div_zero = (divisor == {W{1'b0}});
    w_overflow = !w_div_zero && (dividend[2*W-1:W] >= divisor);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; error cases skip CALC so their result is valid one
  // cycle after the accept.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_div_zero || w_overflow) begin
            w_next_state = DONE;
          end else begin
            w_next_state = CALC;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == CNT_LAST) begin
          w_next_state = DONE;
        end else begin
          w_next_state = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers.
  // r_shift starts as the low dividend half; each CALC edge consumes its MSB
  // and shifts the new quotient bit in at the LSB, so after W edges it holds
  // the quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_divisor   <= {W{1'b0}};
      r_rem       <= {W{1'b0}};
      r_shift     <= {W{1'b0}};
      r_quotient  <= {W{1'b0}};
      r_remainder <= {W{1'b0}};
      r_div_zero  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_divisor <= divisor;
            r_shift   <= dividend[W-1:0];
            r_rem     <= dividend[2*W-1:W];
            r_cnt     <= {CNT_W{1'b0}};
            if (w_div_zero) begin
              r_div_zero  <= 1'b1;
              r_overflow  <= 1'b0;
              r_quotient  <= ERR_ONES;
              r_remainder <= ERR_ONES;
            end else if (w_overflow) begin
              r_div_zero  <= 1'b0;
              r_overflow  <= 1'b1;
              r_quotient  <= ERR_ONES;
              r_remainder <= ERR_ONES;
            end else begin
              r_div_zero <= 1'b0;
              r_overflow <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem   <= w_r_next;
          r_shift <= {r_shift[W-2:0], w_q_bit};
          if (r_cnt == CNT_LAST) begin
            r_quotient  <= {r_shift[W-2:0], w_q_bit};
            r_remainder <= w_r_next;
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Handshake signals decode straight from the state register.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    quotient  = r_quotient;
    remainder = r_remainder;
    div_zero  = r_div_zero;
    overflow  = r_overflow;
  end

endmodule : unsigned_16by8_seq_div
